// File: rtl/note_judge_pkg.sv
// note_judge_pkg: shared FSM encoding, saturation limits and scoring defaults.
package note_judge_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, JUDGED = 2'd2} state_t;
   localparam logic [7:0]  SAT8  = 8'hFF;
   localparam logic [15:0] SAT16 = 16'hFFFF;
   localparam int DEF_BONUS_THRESH = 10;
   localparam int DEF_SCORE_HIT    = 1;
   localparam int DEF_SCORE_BONUS  = 2;
endpackage

// File: rtl/note_judge_btn_sync_edge.sv
// btn_sync_edge: 2-flop synchronizer plus registered rising-edge detect of a raw button.
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);
   logic s1_q, s2_q, s3_q, en_q, seen_q, press_q;
   // an edge only counts once the button has been seen released after reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         en_q    <= 1'b0;
         seen_q  <= 1'b0;
         press_q <= 1'b0;
      end else begin
         s1_q    <= btn_i;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         en_q    <= 1'b1;
         seen_q  <= seen_q | (en_q & ~s1_q);
         press_q <= s2_q & ~s3_q & seen_q;
      end
   end
   assign press_o = press_q;
endmodule

// File: rtl/note_judge.sv
// note_judge: judges synchronized button presses against the note at the judge slot and keeps combo/score.
module note_judge
   import note_judge_pkg::*;
#(
   parameter int BONUS_THRESH = DEF_BONUS_THRESH,
   parameter int SCORE_HIT    = DEF_SCORE_HIT,
   parameter int SCORE_BONUS  = DEF_SCORE_BONUS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        song_active,
   input  logic        note_tick,
   input  logic        note_R_judge,
   input  logic        note_B_judge,
   input  logic        red_button,
   input  logic        blue_button,
   output logic        delete,
   output logic [7:0]  combo,
   output logic [7:0]  max_combo,
   output logic [15:0] score,
   output logic        hit_flash,
   output logic        miss_flash
);
   logic press_r, press_b;
   btn_sync_edge u_red  (.clk(clk), .rst(rst), .btn_i(red_button),  .press_o(press_r));
   btn_sync_edge u_blue (.clk(clk), .rst(rst), .btn_i(blue_button), .press_o(press_b));
   state_t      state_q;
   logic        sa_q, delete_q, hit_q, miss_q;
   logic [7:0]  combo_q, max_q, combo_inc;
   logic [15:0] score_q, pts, score_d;
   logic [16:0] score_sum;
   logic        note_ok, judged, match, rise;
   always_comb begin
      note_ok   = note_R_judge ^ note_B_judge;
      judged    = (press_r | press_b) & note_ok;
      match     = (press_r ^ press_b) & (press_r ? note_R_judge : note_B_judge);
      rise      = song_active & ~sa_q;
      combo_inc = (combo_q == SAT8) ? combo_q : combo_q + 8'd1;
      pts       = (int'(combo_q) >= BONUS_THRESH) ? 16'(SCORE_BONUS) : 16'(SCORE_HIT);
      score_sum = {1'b0, score_q} + {1'b0, pts};
      score_d   = score_sum[16] ? SAT16 : score_sum[15:0];
   end
   // a song start only happens from IDLE, so the clear never collides with a judgement
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         sa_q     <= 1'b0;
         delete_q <= 1'b0;
         hit_q    <= 1'b0;
         miss_q   <= 1'b0;
         combo_q  <= 8'd0;
         max_q    <= 8'd0;
         score_q  <= 16'd0;
      end else begin
         sa_q     <= song_active;
         delete_q <= 1'b0;
         hit_q    <= 1'b0;
         miss_q   <= 1'b0;
         if (!song_active) state_q <= IDLE;
         else begin
            if (rise) begin
               combo_q <= 8'd0;
               max_q   <= 8'd0;
               score_q <= 16'd0;
            end
            case (state_q)
               IDLE, JUDGED: if (note_tick) state_q <= ARMED;
               ARMED: begin
                  if (judged) begin
                     delete_q <= match;
                     hit_q    <= match;
                     miss_q   <= ~match;
                     combo_q  <= match ? combo_inc : 8'd0;
                     max_q    <= (match && combo_inc > max_q) ? combo_inc : max_q;
                     score_q  <= match ? score_d : score_q;
                     state_q  <= note_tick ? ARMED : JUDGED;
                  end else if (note_tick && note_ok) begin
                     miss_q  <= 1'b1;
                     combo_q <= 8'd0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
   assign delete     = delete_q;
   assign hit_flash  = hit_q;
   assign miss_flash = miss_q;
   assign combo      = combo_q;
   assign max_combo  = max_q;
   assign score      = score_q;
endmodule

// File: tb/tb_note_judge.sv
// tb_note_judge: table-driven trials, hand sequences and random stimulus against a rule-level model.
module tb_note_judge;
   logic clk, rst, song_active, note_tick, note_R_judge, note_B_judge, red_button, blue_button;
   logic delete, hit_flash, miss_flash;
   logic [7:0] combo, max_combo;
   logic [15:0] score;
   int vec, bad, n_del, n_hit, n_miss;
   int m_st, m_combo, m_max, m_score;
   logic m_del, m_hit, m_miss, m_sa;
   logic [4:0] rh, bh;

   typedef struct {
      logic nr, nb, r, b;
      int e_del, e_hit, e_miss;
   } trial_t;
   trial_t tbl[10];

   note_judge dut (
      .clk(clk), .rst(rst), .song_active(song_active), .note_tick(note_tick),
      .note_R_judge(note_R_judge), .note_B_judge(note_B_judge),
      .red_button(red_button), .blue_button(blue_button),
      .delete(delete), .combo(combo), .max_combo(max_combo), .score(score),
      .hit_flash(hit_flash), .miss_flash(miss_flash)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int act, input int exp);
      vec++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // raw button history: bit k holds the level sampled k+1 edges ago; reset fills it with
   // "held" so a press needs a genuine post-reset low followed by a high three edges back
   task automatic model_step();
      logic pr, pb;
      int nc;
      if (!rst) begin
         m_st = 0; m_combo = 0; m_max = 0; m_score = 0;
         m_del = 0; m_hit = 0; m_miss = 0; m_sa = 0;
         rh = '1; bh = '1;
         return;
      end
      pr = rh[2] & ~rh[3];
      pb = bh[2] & ~bh[3];
      rh = {rh[3:0], red_button};
      bh = {bh[3:0], blue_button};
      m_del = 0; m_hit = 0; m_miss = 0;
      if (!song_active) begin
         m_st = 0; m_sa = 0;
         return;
      end
      if (!m_sa) begin
         m_combo = 0; m_max = 0; m_score = 0;
      end
      m_sa = 1;
      nc = (note_R_judge && !note_B_judge) ? 1 : (note_B_judge && !note_R_judge) ? 2 : 0;
      if (m_st == 1 && (pr || pb) && nc != 0) begin
         if (pr != pb && (pr ? nc == 1 : nc == 2)) begin
            m_score = m_score + (m_combo >= 10 ? 2 : 1);
            if (m_score > 65535) m_score = 65535;
            m_combo = (m_combo < 255) ? m_combo + 1 : 255;
            if (m_combo > m_max) m_max = m_combo;
            m_del = 1; m_hit = 1;
         end else begin
            m_miss = 1; m_combo = 0;
         end
         m_st = note_tick ? 1 : 2;
      end else if (note_tick) begin
         if (m_st == 1 && nc != 0) begin
            m_miss = 1; m_combo = 0;
         end
         m_st = 1;
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         #1;
         n_del  += int'(delete);
         n_hit  += int'(hit_flash);
         n_miss += int'(miss_flash);
         chk("delete", int'(delete), int'(m_del));
         chk("hit_flash", int'(hit_flash), int'(m_hit));
         chk("miss_flash", int'(miss_flash), int'(m_miss));
         chk("combo", int'(combo), m_combo);
         chk("max_combo", int'(max_combo), m_max);
         chk("score", int'(score), m_score);
      end
   endtask

   task automatic clr();
      n_del = 0; n_hit = 0; n_miss = 0;
   endtask

   task automatic arm();
      note_R_judge = 0; note_B_judge = 0; note_tick = 1;
      cyc(1);
      note_tick = 0;
   endtask

   task automatic press(input logic r, input logic b);
      red_button = r; blue_button = b;
      cyc(2);
      red_button = 0; blue_button = 0;
   endtask

   task automatic hit_r();
      arm();
      note_R_judge = 1;
      press(1, 0);
      cyc(4);
   endtask

   task automatic restart();
      song_active = 0;
      cyc(2);
      song_active = 1;
      cyc(1);
   endtask

   initial begin
      vec = 0; bad = 0; clr();
      m_st = 0; m_combo = 0; m_max = 0; m_score = 0;
      m_del = 0; m_hit = 0; m_miss = 0; m_sa = 0; rh = '1; bh = '1;
      rst = 0; song_active = 0; note_tick = 0; note_R_judge = 0; note_B_judge = 0;
      red_button = 0; blue_button = 0;
      tbl[0] = '{1, 0, 1, 0, 1, 1, 0};
      tbl[1] = '{0, 1, 0, 1, 1, 1, 0};
      tbl[2] = '{0, 1, 1, 0, 0, 0, 1};
      tbl[3] = '{1, 0, 0, 1, 0, 0, 1};
      tbl[4] = '{1, 0, 1, 1, 0, 0, 1};
      tbl[5] = '{0, 0, 1, 0, 0, 0, 0};
      tbl[6] = '{1, 1, 1, 0, 0, 0, 0};
      tbl[7] = '{1, 1, 1, 1, 0, 0, 0};
      tbl[8] = '{0, 1, 1, 1, 0, 0, 1};
      tbl[9] = '{1, 0, 0, 0, 0, 0, 0};
      cyc(2);
      chk("rst_delete", int'(delete), 0);
      chk("rst_combo", int'(combo), 0);
      chk("rst_max", int'(max_combo), 0);
      chk("rst_score", int'(score), 0);
      chk("rst_flash", int'(hit_flash) + int'(miss_flash), 0);
      rst = 1; song_active = 1;
      cyc(2);
      // first hit and press-to-delete latency
      arm();
      note_R_judge = 1;
      cyc(1);
      red_button = 1;
      cyc(1); chk("lat_n", int'(delete), 0);
      cyc(1); chk("lat_n1", int'(delete), 0);
      red_button = 0;
      cyc(1); chk("lat_n2", int'(delete), 0);
      cyc(1);
      chk("lat_n3_delete", int'(delete), 1);
      chk("first_hit_flash", int'(hit_flash), 1);
      chk("first_combo", int'(combo), 1);
      chk("first_score", int'(score), 1);
      cyc(1); chk("delete_one_cycle", int'(delete), 0);
      // bonus threshold
      restart();
      chk("restart_score", int'(score), 0);
      repeat (10) hit_r();
      chk("ten_score", int'(score), 10);
      chk("ten_combo", int'(combo), 10);
      hit_r();
      chk("eleven_score", int'(score), 12);
      chk("eleven_max", int'(max_combo), 11);
      // timeout miss
      arm();
      note_R_judge = 1;
      cyc(2);
      note_tick = 1;
      cyc(1);
      note_tick = 0;
      chk("timeout_flash", int'(miss_flash), 1);
      chk("timeout_combo", int'(combo), 0);
      chk("timeout_max", int'(max_combo), 11);
      // wrong colour, then a second press before the next tick
      hit_r();
      arm();
      note_B_judge = 1;
      clr(); press(1, 0); cyc(4);
      chk("wrong_miss", n_miss, 1);
      chk("wrong_del", n_del, 0);
      chk("wrong_combo", int'(combo), 0);
      clr(); press(1, 0); cyc(4);
      chk("second_ignored", n_miss + n_hit + n_del, 0);
      // press coinciding with note_tick
      arm();
      note_R_judge = 1;
      cyc(1);
      red_button = 1;
      cyc(2);
      red_button = 0;
      cyc(1);
      note_tick = 1;
      cyc(1);
      note_tick = 0;
      chk("tick_press_hit", int'(hit_flash), 1);
      chk("tick_press_del", int'(delete), 1);
      clr(); press(1, 0); cyc(4);
      chk("new_slot_armed", n_hit, 1);
      // single-slot trials
      for (int i = 0; i < 10; i++) begin
         arm();
         note_R_judge = tbl[i].nr; note_B_judge = tbl[i].nb;
         cyc(1);
         clr(); press(tbl[i].r, tbl[i].b); cyc(4);
         chk($sformatf("tbl%0d_del", i), n_del, tbl[i].e_del);
         chk($sformatf("tbl%0d_hit", i), n_hit, tbl[i].e_hit);
         chk($sformatf("tbl%0d_miss", i), n_miss, tbl[i].e_miss);
      end
      // combo saturation
      restart();
      repeat (260) hit_r();
      chk("sat_combo", int'(combo), 255);
      chk("sat_max", int'(max_combo), 255);
      chk("sat_score", int'(score), 510);
      // song end holds values and ignores presses
      song_active = 0;
      note_R_judge = 1;
      clr(); press(1, 0); cyc(5);
      chk("idle_hold_combo", int'(combo), 255);
      chk("idle_hold_score", int'(score), 510);
      chk("idle_no_pulse", n_del + n_hit + n_miss, 0);
      // reset mid-song with a held button
      song_active = 1;
      restart();
      repeat (5) hit_r();
      chk("pre_rst_combo", int'(combo), 5);
      red_button = 1;
      rst = 0;
      cyc(1);
      chk("midrst_combo", int'(combo), 0);
      chk("midrst_score", int'(score), 0);
      chk("midrst_max", int'(max_combo), 0);
      cyc(1);
      rst = 1;
      arm();
      note_R_judge = 1;
      clr(); cyc(8);
      chk("held_no_delete", n_del, 0);
      red_button = 0;
      cyc(2);
      clr(); press(1, 0); cyc(4);
      chk("fresh_press_delete", n_del, 1);
      // random traffic
      for (int i = 0; i < 4000; i++) begin
         logic prev_tick;
         prev_tick = note_tick;
         rst = ($urandom_range(0, 799) != 0);
         if ($urandom_range(0, 249) == 0) song_active = ~song_active;
         note_tick = ($urandom_range(0, 5) == 0);
         if (prev_tick) {note_R_judge, note_B_judge} = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) red_button = ~red_button;
         if ($urandom_range(0, 3) == 0) blue_button = ~blue_button;
         cyc(1);
      end
      rst = 1;
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule

// File: doc/note_judge.md
NOTE_JUDGE -- requirements
Module: note_judge

Interface
REQ-001 Parameters: BONUS_THRESH, default 10, combo at or above which a hit scores the bonus value; SCORE_HIT, default 1, base points per hit; SCORE_BONUS, default 2, points per hit at or above threshold.
REQ-002 clk  input  1  single system clock; every register is clocked on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 song_active  input  1  high while the note shifter is playing; low means idle or finished.
REQ-005 note_tick  input  1  one-cycle pulse each time the note lane advances by one slot.
REQ-006 note_R_judge  input  1  red note present at the judge position.
REQ-007 note_B_judge  input  1  blue note present at the judge position.
REQ-008 red_button  input  1  raw, asynchronous, level-high red player button.
REQ-009 blue_button  input  1  raw, asynchronous, level-high blue player button.
REQ-010 delete  output  1  one-cycle pulse that clears the judged note in the shifter.
REQ-011 combo  output  8  current consecutive-hit count.
REQ-012 max_combo  output  8  highest combo reached in the current song.
REQ-013 score  output  16  accumulated score.
REQ-014 hit_flash, miss_flash  output  1 each  one-cycle event pulses.

Function
REQ-015 Each raw button passes through a 2-flop synchronizer; a press is the rising edge of the synchronized level, detected against a third flop.
REQ-016 FSM states are IDLE, ARMED and JUDGED.
REQ-017 IDLE to ARMED on the first note_tick while song_active is high.
REQ-018 ARMED to JUDGED on a press.
REQ-019 JUDGED to ARMED on note_tick.
REQ-020 Any state goes to IDLE when song_active is low.
REQ-021 Hit condition: in ARMED, exactly one press, and its colour matches the single asserted judge input.
REQ-022 On a hit, the following cycle: delete=1, hit_flash=1, combo+1, score incremented, max_combo updated if combo exceeds it.
REQ-023 Delete latency: raw button high before edge N gives delete high in the cycle after edge N+3.
REQ-024 Hit score = SCORE_BONUS if the pre-increment combo is at least BONUS_THRESH, else SCORE_HIT.
REQ-025 Miss (wrong colour): in ARMED, press colour does not match the asserted note -> miss_flash=1, combo=0, no delete, go to JUDGED.
REQ-026 Miss (both buttons): red and blue presses in the same cycle with a note present -> miss.
REQ-027 Miss (timeout): note_tick arrives in ARMED while a judge input is high and no press occurred -> miss_flash=1, combo=0.
REQ-028 Press while neither judge input is high: ignored; no flash, no state change.
REQ-029 Presses in JUDGED or IDLE are ignored.
REQ-030 Press and note_tick in the same cycle: the press is judged against the pre-tick note, then the FSM enters ARMED for the new slot.
REQ-031 combo saturates at 255, max_combo at 255, score at 65535.
REQ-032 On the rising edge of song_active: combo, max_combo and score clear to 0 in that cycle.
REQ-033 When song_active falls: outputs hold their values, and delete and flashes stay 0.
REQ-034 note_R_judge and note_B_judge both high: treated as no note.

Reset
REQ-035 rst low: FSM=IDLE; delete, hit_flash, miss_flash, combo, max_combo, score = 0; synchronizer flops = 0.
REQ-036 Reset mid-song discards any pending press.
REQ-037 First activity after rst deasserts requires a fresh note_tick.

Structure
REQ-038 Shared package holds: FSM state encoding, 8-bit and 16-bit saturation limits, default BONUS_THRESH/SCORE_HIT/SCORE_BONUS.
REQ-039 One sub-module, btn_sync_edge (synchronizer plus rising-edge detect), instantiated once per button.
REQ-040 Target size: 150-250 lines of RTL.

Verification
REQ-041 Tick, note_R_judge=1, red press -> delete pulse 1 cycle, combo 0->1, score 0->1, hit_flash=1.
REQ-042 10 consecutive hits, then an 11th -> score 10 after ten hits; 11th adds 2 giving 12; max_combo=11.
REQ-043 note_B_judge=1, red press -> miss_flash, combo 0, no delete; a second press before the next tick is ignored.
REQ-044 note_R_judge=1 and no press until next tick -> miss_flash on that tick, combo reset, max_combo unchanged.
REQ-045 Red press in the same cycle as note_tick, pre-tick note red -> hit counted; new slot ARMED.
REQ-046 rst low mid-song with combo=5 -> all outputs 0; button held through reset produces no delete until released and pressed again.
